// File: rtl/if_fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// State codes, default parameter values and the modulo-2^32 address step.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DROP  = 2'd2
  } if_state_e;

  localparam logic [31:0] IF_DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] IF_DEFAULT_PC_STEP    = 32'd4;

  // Plain 32-bit add: carries out of bit 31 are dropped, so the top word wraps to 0.
  function automatic logic [31:0] if_step_addr(input logic [31:0] addr, input logic [31:0] step);
    return addr + step;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a variable-latency req/ack
// instruction port, redirects on taken branches and stalls under hazard freeze.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = IF_DEFAULT_RESET_ADDR,
  parameter logic [31:0] PC_STEP    = IF_DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] PC,
  output logic [31:0] instruction
);

  if_state_e   state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic [31:0] seq_addr_s;

  assign seq_addr_s = if_step_addr(req_addr_q, PC_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IF_FETCH;
      req_addr_q  <= RESET_ADDR;
      pend_addr_q <= 32'h0000_0000;
      inst_buf_q  <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      pend_addr_q <= pend_addr_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    pend_addr_d = pend_addr_q;
    inst_buf_d  = inst_buf_q;
    case (state_q)
      IF_FETCH: begin
        if (branch_taken) begin
          if (imem_ack) begin
            // The returning word is on the wrong path; retarget immediately.
            req_addr_d = branch_addr;
          end else begin
            // The request must still complete before the target can be issued.
            pend_addr_d = branch_addr;
            state_d     = IF_DROP;
          end
        end else if (imem_ack) begin
          if (freeze) begin
            inst_buf_d = imem_rdata;
            state_d    = IF_HOLD;
          end else begin
            req_addr_d = seq_addr_s;
          end
        end else begin
          state_d = IF_FETCH;
        end
      end
      IF_HOLD: begin
        if (branch_taken) begin
          req_addr_d = branch_addr;
          inst_buf_d = 32'h0000_0000;
          state_d    = IF_FETCH;
        end else if (!freeze) begin
          req_addr_d = seq_addr_s;
          state_d    = IF_FETCH;
        end else begin
          state_d = IF_HOLD;
        end
      end
      IF_DROP: begin
        // Newest branch target wins, including one arriving with the ack.
        if (branch_taken) begin
          pend_addr_d = branch_addr;
        end else begin
          pend_addr_d = pend_addr_q;
        end
        if (imem_ack) begin
          req_addr_d = branch_taken ? branch_addr : pend_addr_q;
          state_d    = IF_FETCH;
        end else begin
          state_d = IF_DROP;
        end
      end
      default: begin
        state_d    = IF_FETCH;
        req_addr_d = RESET_ADDR;
      end
    endcase
  end

  always_comb begin
    imem_addr   = req_addr_q;
    imem_req    = 1'b0;
    if_valid    = 1'b0;
    PC          = 32'h0000_0000;
    instruction = 32'h0000_0000;
    case (state_q)
      IF_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && !branch_taken) begin
          if_valid    = 1'b1;
          PC          = seq_addr_s;
          instruction = imem_rdata;
        end else begin
          if_valid = 1'b0;
        end
      end
      IF_HOLD: begin
        imem_req    = 1'b0;
        if_valid    = 1'b1;
        PC          = seq_addr_s;
        instruction = inst_buf_q;
      end
      IF_DROP: begin
        imem_req = 1'b1;
        if_valid = 1'b0;
      end
      default: begin
        imem_req = 1'b0;
        if_valid = 1'b0;
      end
    endcase
  end

endmodule
